// File: rtl/spt_autobuf_seq.sv
// spt_autobuf_seq: per-channel SPORT autobuffer DMA sequencer (steal request, pointer walk, overrun flag).
// Define AB_WRAP_IRQ_EN to enable the one-cycle circular-wrap interrupt on AB_IRQ.
module spt_autobuf_seq #(
  parameter int AW  = 14,
  parameter int NCH = 4
) (
  input  logic           DSPCLK,
  input  logic           T_RSTn,
  input  logic           CFG_WE,
  input  logic [1:0]     CFG_SEL,
  input  logic [1:0]     CFG_FLD,
  input  logic [AW-1:0]  CFG_DI,
  input  logic [NCH-1:0] WRDY,
  input  logic [NCH-1:0] Sack,
  output logic [NCH-1:0] Sreqi,
  output logic [AW-1:0]  AB_ADDR,
  output logic [NCH-1:0] AB_OVF,
  output logic [NCH-1:0] AB_IRQ
);
  typedef enum logic [1:0] {DIS, IDLE, REQ, UPD} st_t;
  logic [AW-1:0] ptr_a [NCH];
  always_comb begin
    AB_ADDR = '0;
    for (int i = NCH - 1; i >= 0; i--) if (Sack[i]) AB_ADDR = ptr_a[i];
  end
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    st_t st, st_n;
    logic [AW-1:0] base, len, mod, ptr, b_e, l_e, m_e, p_e, nxt;
    logic [AW:0] sum;
    logic ena, pend, ovf, wrap, sel, wb, wl, wm, wc;
    assign sel = CFG_WE && CFG_SEL == 2'(c);
    assign wb = sel && CFG_FLD == 2'd0;
    assign wl = sel && CFG_FLD == 2'd1;
    assign wm = sel && CFG_FLD == 2'd2;
    assign wc = sel && CFG_FLD == 2'd3;
    // Same-edge config writes feed the pointer update so UPD sees the new values.
    always_comb begin
      b_e = wb ? CFG_DI : base;
      l_e = wl ? CFG_DI : len;
      m_e = wm ? CFG_DI : mod;
      p_e = wb ? CFG_DI : ptr;
      sum = {1'b0, p_e} + {1'b0, m_e};
      wrap = l_e != '0 && sum >= {1'b0, b_e} + {1'b0, l_e};
      nxt = AW'(sum - (wrap ? {1'b0, l_e} : '0));
    end
    always_comb begin
      st_n = st;
      if ((wc && !CFG_DI[0]) || !ena) st_n = DIS;
      else
        unique case (st)
          DIS:  st_n = IDLE;
          IDLE: st_n = WRDY[c] ? REQ : IDLE;
          REQ:  st_n = Sack[c] ? UPD : REQ;
          UPD:  st_n = (pend || WRDY[c]) ? REQ : IDLE;
        endcase
    end
    always_ff @(posedge DSPCLK or negedge T_RSTn)
      if (!T_RSTn) begin
        st   <= DIS;
        base <= '0;
        len  <= '0;
        mod  <= '0;
        ptr  <= '0;
        ena  <= 1'b0;
        pend <= 1'b0;
        ovf  <= 1'b0;
      end else begin
        st <= st_n;
        if (wb) base <= CFG_DI;
        if (wl) len <= CFG_DI;
        if (wm) mod <= CFG_DI;
        if (wc) ena <= CFG_DI[0];
        ptr  <= (st == UPD && st_n != DIS) ? nxt : p_e;
        pend <= st == REQ && st_n != DIS && (pend || WRDY[c]);
        ovf  <= wc ? 1'b0 : ovf || (WRDY[c] && pend && (st == REQ || st == UPD));
      end
    assign Sreqi[c]  = st == REQ;
    assign AB_OVF[c] = ovf;
    assign ptr_a[c]  = ptr;
`ifdef AB_WRAP_IRQ_EN
    logic irq;
    always_ff @(posedge DSPCLK or negedge T_RSTn)
      if (!T_RSTn) irq <= 1'b0;
      else irq <= st == UPD && st_n != DIS && wrap;
    assign AB_IRQ[c] = irq;
`else
    assign AB_IRQ[c] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_spt_autobuf_seq.sv
// tb_spt_autobuf_seq: directed and randomized checks of spt_autobuf_seq against an occupancy-count model.
module tb_spt_autobuf_seq;
  localparam int AW = 14;
  localparam int NCH = 4;
`ifdef AB_WRAP_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif
  logic DSPCLK = 1'b0, T_RSTn = 1'b0, CFG_WE = 1'b0;
  logic [1:0] CFG_SEL = '0, CFG_FLD = '0;
  logic [AW-1:0] CFG_DI = '0, AB_ADDR;
  logic [NCH-1:0] WRDY = '0, Sack = '0, Sreqi, AB_OVF, AB_IRQ;
  int n_vec = 0, n_bad = 0;
  // Model: m_out = accepted words not yet moved, m_gap = the update cycle after an ack, m_act 0 off / 1 waking / 2 live.
  int m_base[NCH], m_len[NCH], m_mod[NCH], m_ptr[NCH], m_act[NCH], m_out[NCH];
  bit m_gap[NCH], m_wrap[NCH], m_ovf[NCH], m_irq[NCH];

  always #5 DSPCLK = ~DSPCLK;

  spt_autobuf_seq #(.AW(AW), .NCH(NCH)) dut (
    .DSPCLK(DSPCLK), .T_RSTn(T_RSTn), .CFG_WE(CFG_WE), .CFG_SEL(CFG_SEL), .CFG_FLD(CFG_FLD),
    .CFG_DI(CFG_DI), .WRDY(WRDY), .Sack(Sack), .Sreqi(Sreqi), .AB_ADDR(AB_ADDR),
    .AB_OVF(AB_OVF), .AB_IRQ(AB_IRQ)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_req(input int c);
    return m_act[c] == 2 && m_out[c] > 0 && !m_gap[c];
  endfunction

  task automatic m_reset();
    for (int c = 0; c < NCH; c++) begin
      m_base[c] = 0; m_len[c] = 0; m_mod[c] = 0; m_ptr[c] = 0; m_act[c] = 0; m_out[c] = 0;
      m_gap[c] = 0; m_wrap[c] = 0; m_ovf[c] = 0; m_irq[c] = 0;
    end
  endtask

  task automatic cycle();
    logic [NCH-1:0] w, s, er, eo, ei;
    logic [AW-1:0] ea, di;
    logic [1:0] sel, fld;
    logic we;
    bit req0, cw;
    int p;
    #1;
    ea = '0;
    for (int i = NCH - 1; i >= 0; i--) if (Sack[i]) ea = AW'(m_ptr[i]);
    for (int i = 0; i < NCH; i++) begin
      er[i] = m_req(i); eo[i] = m_ovf[i]; ei[i] = m_irq[i];
    end
    chk("sreqi", Sreqi, er);
    chk("addr", AB_ADDR, ea);
    chk("ovf", AB_OVF, eo);
    chk("irq", AB_IRQ, ei);
    w = WRDY; s = Sack; we = CFG_WE; sel = CFG_SEL; fld = CFG_FLD; di = CFG_DI;
    @(posedge DSPCLK);
    #1;
    for (int c = 0; c < NCH; c++) begin
      req0 = m_req(c);
      cw = we && sel == 2'(c);
      m_irq[c] = 0;
      if (cw && fld == 2'd3 && !di[0]) begin
        m_act[c] = 0; m_out[c] = 0; m_gap[c] = 0;
      end else if (m_act[c] == 1) m_act[c] = 2;
      else if (m_act[c] == 2) begin
        if (m_gap[c]) m_irq[c] = IRQ_ON && m_wrap[c];
        if (w[c]) begin
          if (m_out[c] < (m_gap[c] ? 1 : 2)) m_out[c]++;
          else m_ovf[c] = 1;
        end
        m_gap[c] = 0;
        if (s[c] && req0) begin
          m_out[c]--;
          m_gap[c] = 1;
          p = m_ptr[c] + m_mod[c];
          m_wrap[c] = m_len[c] != 0 && p >= m_base[c] + m_len[c];
          if (m_wrap[c]) p -= m_len[c];
          m_ptr[c] = p % (1 << AW);
        end
      end
      if (cw)
        case (fld)
          2'd0: begin m_base[c] = int'(di); m_ptr[c] = int'(di); end
          2'd1: m_len[c] = int'(di);
          2'd2: m_mod[c] = int'(di);
          default: begin
            m_ovf[c] = 0;
            if (di[0] && m_act[c] == 0) m_act[c] = 1;
          end
        endcase
    end
    WRDY = '0; Sack = '0; CFG_WE = 1'b0;
  endtask

  task automatic cfg(input int c, input int f, input int v);
    CFG_WE = 1'b1; CFG_SEL = 2'(c); CFG_FLD = 2'(f); CFG_DI = AW'(v);
    cycle();
  endtask

  task automatic ack(input int c, input logic [31:0] exp, input string tag);
    for (int i = 0; i < 10 && !Sreqi[c]; i++) cycle();
    chk({tag, "_req"}, Sreqi[c], 1);
    Sack[c] = 1'b1;
    #1;
    chk(tag, AB_ADDR, exp);
    cycle();
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge DSPCLK);
    #1;
    chk("rst0_sreqi", Sreqi, 0);
    chk("rst0_addr", AB_ADDR, 0);
    chk("rst0_ovf", AB_OVF, 0);
    chk("rst0_irq", AB_IRQ, 0);
    T_RSTn = 1'b1;
    cycle();
    // ch1 circular buffer of four words
    cfg(1, 0, 'h100); cfg(1, 1, 4); cfg(1, 2, 1); cfg(1, 3, 1); cycle();
    for (int k = 0; k < 5; k++) begin
      WRDY[1] = 1'b1; cycle();
      ack(1, 'h100 + k % 4, "ch1_addr");
      cycle();
      chk("ch1_irq", AB_IRQ[1], (k == 3) ? IRQ_ON : 1'b0);
    end
    // ch0 linear wrap past the top of memory
    cfg(0, 0, 'h3FFE); cfg(0, 2, 3); cfg(0, 3, 1); cycle();
    for (int k = 0; k < 2; k++) begin
      WRDY[0] = 1'b1; cycle();
      ack(0, (k == 0) ? 'h3FFE : 'h0001, "ch0_addr");
      cycle();
      chk("ch0_irq", AB_IRQ[0], 0);
    end
    // ch2 overrun
    cfg(2, 0, 'h200); cfg(2, 1, 8); cfg(2, 2, 2); cfg(2, 3, 1); cycle();
    WRDY[2] = 1'b1; cycle();
    WRDY[2] = 1'b1; cycle();
    chk("ch2_ovf_pend", AB_OVF[2], 0);
    WRDY[2] = 1'b1; cycle();
    chk("ch2_ovf", AB_OVF[2], 1);
    ack(2, 'h200, "ch2_addr0");
    ack(2, 'h202, "ch2_addr1");
    repeat (3) cycle();
    chk("ch2_idle", Sreqi[2], 0);
    chk("ch2_ovf_sticky", AB_OVF[2], 1);
    cfg(2, 3, 1);
    chk("ch2_ovf_clr", AB_OVF[2], 0);
    // simultaneous acks on ch0 and ch3
    cfg(3, 0, 'h300); cfg(3, 2, 5); cfg(3, 3, 1); cycle();
    WRDY = 4'b1001; cycle();
    chk("dual_req", Sreqi, 4'b1001);
    Sack = 4'b1001;
    #1;
    chk("dual_addr", AB_ADDR, 'h0004);
    cycle(); cycle();
    WRDY = 4'b1001; cycle();
    ack(3, 'h305, "ch3_adv");
    ack(0, 'h0007, "ch0_adv");
    cycle(); cycle();
    // disable mid-request, then asynchronous reset mid-request
    WRDY[3] = 1'b1; cycle();
    chk("ch3_req", Sreqi[3], 1);
    cfg(3, 3, 0);
    chk("ch3_dis", Sreqi[3], 0);
    for (int k = 0; k < 3; k++) begin
      WRDY[1] = 1'b1; cycle();
    end
    chk("ch1_req_pre", Sreqi[1], 1);
    chk("ch1_ovf_pre", AB_OVF[1], 1);
    T_RSTn = 1'b0;
    #1;
    chk("rst_sreqi", Sreqi, 0);
    chk("rst_ovf", AB_OVF, 0);
    chk("rst_irq", AB_IRQ, 0);
    chk("rst_addr", AB_ADDR, 0);
    m_reset();
    @(posedge DSPCLK);
    #1;
    T_RSTn = 1'b1;
    cycle();
    // randomized traffic on all channels
    for (int c = 0; c < NCH; c++) begin
      cfg(c, 0, $urandom_range('h3FFF, 0));
      cfg(c, 1, ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(12, 1));
      cfg(c, 2, $urandom_range(7, 0));
      cfg(c, 3, 1);
    end
    cycle();
    repeat (500) begin
      WRDY = 4'($urandom) & 4'($urandom);
      for (int c = 0; c < NCH; c++) Sack[c] = m_req(c) && $urandom_range(1, 0) == 1;
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/spt_autobuf_seq.md
SPT_AUTOBUF_SEQ -- requirements
Module: spt_autobuf_seq

Interface
REQ-001 Parameter: AW, 14, data-memory address and length width.
REQ-002 Parameter: NCH, 4, channel count: ch0=TX0, ch1=RX0, ch2=TX1, ch3=RX1, in steal-priority order.
REQ-003 Port: DSPCLK  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port: T_RSTn  in  1  reset, asynchronous, active-low.
REQ-005 Port: CFG_WE  in  1  configuration write strobe, one cycle.
REQ-006 Port: CFG_SEL  in  2  target channel of the write.
REQ-007 Port: CFG_FLD  in  2  field: 0=BASE, 1=LEN, 2=MOD, 3=CTL (bit0 ENA; other bits ignored).
REQ-008 Port: CFG_DI  in  AW  write data.
REQ-009 Port: WRDY  in  NCH  per-channel one-cycle pulse: the SPORT has a word to move (RX full / TX empty).
REQ-010 Port: Sack  in  NCH  per-channel steal acknowledge from the steal controller, one-cycle pulse.
REQ-011 Port: Sreqi  out  NCH  per-channel steal request to the steal controller.
REQ-012 Port: AB_ADDR  out  AW  DM address for the transfer being acknowledged this cycle.
REQ-013 Port: AB_OVF  out  NCH  sticky overrun flag per channel.
REQ-014 Port: AB_IRQ  out  NCH  one-cycle buffer-wrap interrupt per channel.

Function
REQ-015 Per channel: registers BASE, LEN, MOD, ENA, pointer PTR (AW bits), pending flag PEND, FSM {DIS, IDLE, REQ, UPD}.
REQ-016 CFG_WE with FLD=BASE writes BASE and loads PTR<=CFG_DI the same edge; the FSM is unchanged.
REQ-017 DIS: Sreqi=0; entered whenever ENA=0; ENA 0->1 moves DIS->IDLE next edge with PEND cleared.
REQ-018 IDLE: WRDY -> REQ next edge.
REQ-019 REQ: Sreqi=1 (registered; asserts the cycle after the WRDY edge); Sack -> UPD next edge.
REQ-020 AB_ADDR = PTR of the lowest-index channel with Sack=1 that cycle, else 0; combinational.
REQ-021 UPD: Sreqi=0; PTR<=NXT; then REQ if PEND (PEND cleared) else IDLE.
REQ-022 NXT = PTR+MOD computed AW+1 bits wide; if LEN!=0 and NXT >= BASE+LEN then NXT-LEN (circular); if LEN=0, linear wrap modulo 2^AW with no IRQ.
REQ-023 AB_IRQ[ch] pulses for one cycle, the cycle after UPD, when the circular wrap in REQ-022 was taken.
REQ-024 WRDY in REQ or UPD with PEND=0 sets PEND; WRDY with PEND=1 sets AB_OVF[ch]; the word is dropped and PTR is unchanged.
REQ-025 AB_OVF[ch] clears only on a CFG write to CTL of that channel or on reset.
REQ-026 Writing ENA=0 in any state: next edge DIS, Sreqi drops, PEND cleared; a Sack in that same cycle still yields AB_ADDR but PTR does not advance.
REQ-027 Channels are independent; simultaneous WRDY/Sack on several channels are each handled in the same cycle.
REQ-028 A CFG write to BASE/LEN/MOD during REQ or UPD takes effect on that edge; UPD uses the updated values.

Reset
REQ-029 T_RSTn low: all FSMs DIS; BASE, LEN, MOD, PTR, ENA, PEND = 0; Sreqi, AB_OVF, AB_IRQ = 0 immediately (asynchronous); AB_ADDR = 0.
REQ-030 Deassertion is honoured at the next DSPCLK edge; a reset mid-REQ loses the request with no Sack side effects.

Configuration
REQ-031 Macro AB_WRAP_IRQ_EN: defined -> AB_IRQ behaves per REQ-023; undefined -> AB_IRQ tied 0 and the wrap-detect register is removed; pointer wrap arithmetic is unchanged.

Verification
REQ-032 ch1 BASE=0x100, LEN=4, MOD=1, ENA=1; 5 WRDY/Sack pairs -> AB_ADDR 0x100,0x101,0x102,0x103,0x100; AB_IRQ[1] one pulse after the 4th UPD.
REQ-033 ch0 MOD=3, LEN=0, BASE=0x3FFE -> AB_ADDR 0x3FFE then 0x0001; no AB_IRQ.
REQ-034 ch2 three WRDY before any Sack -> PEND set on the 2nd, AB_OVF[2]=1 on the 3rd; two transfers performed; a CTL write clears AB_OVF[2].
REQ-035 Sack[0] and Sack[3] in the same cycle -> AB_ADDR = PTR0; both PTRs advance.
REQ-036 ch3 in REQ, ENA=0 write -> Sreqi[3]=0 next cycle; T_RSTn pulsed mid-REQ on ch1 -> all outputs 0 immediately.
